// File: rtl/led_frame_sched.sv
// led_frame_sched: LED panel frame scheduler with buffer flip and shadowed driver config.
// Optional frame watchdog is built when FRAME_WATCHDOG_EN is defined.
module led_frame_sched #(
    parameter int CTRL_REG_WIDTH = 32,
    parameter int N_ROWS_MAX     = 64,
    parameter int N_COLS_MAX     = 256,
    parameter int BITDEPTH_MAX   = 8,
    parameter int LSB_BLANK_MAX  = 200,
    parameter int RST_CYCLES     = 4,
    parameter int WDOG_CYCLES    = 2**24
) (
    input  logic                      clk,
    input  logic                      ctrl_rst_n,
    input  logic                      sw_en,
    input  logic [CTRL_REG_WIDTH-1:0] sw_n_rows,
    input  logic [CTRL_REG_WIDTH-1:0] sw_n_cols,
    input  logic [CTRL_REG_WIDTH-1:0] sw_bitdepth,
    input  logic [CTRL_REG_WIDTH-1:0] sw_lsb_blank,
    input  logic [CTRL_REG_WIDTH-1:0] sw_brightness,
    input  logic                      sw_cfg_wr,
    input  logic                      sw_swap_req,
    input  logic                      disp_sync,
    output logic                      drv_en,
    output logic                      drv_rst,
    output logic [CTRL_REG_WIDTH-1:0] drv_n_rows,
    output logic [CTRL_REG_WIDTH-1:0] drv_n_cols,
    output logic [CTRL_REG_WIDTH-1:0] drv_bitdepth,
    output logic [CTRL_REG_WIDTH-1:0] drv_lsb_blank,
    output logic [CTRL_REG_WIDTH-1:0] drv_brightness,
    output logic                      drv_buffer,
    output logic                      wr_buffer,
    output logic                      swap_done,
    output logic                      cfg_done,
    output logic                      cfg_err,
    output logic                      busy,
    output logic                      wdog_err
);
    localparam int W    = CTRL_REG_WIDTH;
    localparam int RC_W = $clog2(RST_CYCLES + 1);

    localparam logic [W-1:0]    L_ONE   = W'(1);
    localparam logic [W-1:0]    L_TWO   = W'(2);
    localparam logic [W-1:0]    L_ROWS  = W'(N_ROWS_MAX);
    localparam logic [W-1:0]    L_COLS  = W'(N_COLS_MAX);
    localparam logic [W-1:0]    L_BITS  = W'(BITDEPTH_MAX);
    localparam logic [W-1:0]    L_BLANK = W'(LSB_BLANK_MAX);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_DRV_RST,
        S_RUN
    } state_t;

    state_t          r_state;
    logic [RC_W-1:0] r_rst_cnt;
    logic            r_sync_q;
    logic            r_drv_en;
    logic            r_drv_rst;
    logic            r_drv_buf;
    logic            r_swap_pend;
    logic            r_cfg_pend;
    logic            r_swap_done;
    logic            r_cfg_done;
    logic            r_cfg_err;
    logic [W-1:0]    r_drv_rows;
    logic [W-1:0]    r_drv_cols;
    logic [W-1:0]    r_drv_bits;
    logic [W-1:0]    r_drv_blank;
    logic [W-1:0]    r_drv_bright;
    logic [W-1:0]    r_pend_rows;
    logic [W-1:0]    r_pend_cols;
    logic [W-1:0]    r_pend_bits;
    logic [W-1:0]    r_pend_blank;
    logic [W-1:0]    r_pend_bright;

    logic w_sync_evt;
    logic w_cfg_ok;
    logic w_cfg_apply;
    logic w_wd_hit;

    assign w_sync_evt  = disp_sync & ~r_sync_q;
    assign w_cfg_apply = (r_state == S_RUN) & w_sync_evt & r_cfg_pend;

    assign w_cfg_ok = (sw_n_rows >= L_TWO) && (sw_n_rows <= L_ROWS)
                   && !sw_n_rows[0]
                   && (sw_n_cols >= L_ONE) && (sw_n_cols <= L_COLS)
                   && (sw_bitdepth >= L_ONE) && (sw_bitdepth <= L_BITS)
                   && (sw_lsb_blank >= L_ONE) && (sw_lsb_blank <= L_BLANK)
                   && (sw_brightness < sw_lsb_blank);

    // Previous sample of the driver frame-end strobe for edge detection
    always_ff @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            r_sync_q <= 1'b0;
        end else begin
            r_sync_q <= disp_sync;
        end
    end

`ifdef FRAME_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wdog_err;

    assign w_wd_hit = (r_state == S_RUN) && !w_sync_evt && (r_wd_cnt == WD_LAST);

    // Count RUN cycles since the last frame sync; a full timeout restarts the driver
    always_ff @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            r_wd_cnt   <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= w_wd_hit & sw_en;
            if (!sw_en || (r_state != S_RUN) || w_sync_evt || w_wd_hit) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_wd_hit = 1'b0;
    assign wdog_err = 1'b0;
`endif

    // Scheduler FSM: driver reset sequencing, pending work and shadow config
    always_ff @(posedge clk or negedge ctrl_rst_n) begin
        if (!ctrl_rst_n) begin
            r_state       <= S_OFF;
            r_rst_cnt     <= '0;
            r_drv_en      <= 1'b0;
            r_drv_rst     <= 1'b1;
            r_drv_buf     <= 1'b0;
            r_swap_pend   <= 1'b0;
            r_cfg_pend    <= 1'b0;
            r_swap_done   <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_drv_rows    <= L_ROWS;
            r_drv_cols    <= L_COLS;
            r_drv_bits    <= L_BITS;
            r_drv_blank   <= L_BLANK;
            r_drv_bright  <= '0;
            r_pend_rows   <= '0;
            r_pend_cols   <= '0;
            r_pend_bits   <= '0;
            r_pend_blank  <= '0;
            r_pend_bright <= '0;
        end else begin
            r_swap_done <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_cfg_err   <= sw_cfg_wr & ~w_cfg_ok;
            if (!sw_en) begin
                r_state     <= S_OFF;
                r_rst_cnt   <= '0;
                r_drv_en    <= 1'b0;
                r_drv_rst   <= 1'b1;
                r_swap_pend <= 1'b0;
                r_cfg_pend  <= 1'b0;
            end else begin
                unique case (r_state)
                    S_OFF: begin
                        r_state   <= S_DRV_RST;
                        r_rst_cnt <= '0;
                    end
                    S_DRV_RST: begin
                        if (r_rst_cnt == RC_LAST) begin
                            r_state   <= S_RUN;
                            r_drv_rst <= 1'b0;
                            r_drv_en  <= 1'b1;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + RC_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (w_sync_evt && r_swap_pend) begin
                            r_drv_buf   <= ~r_drv_buf;
                            r_swap_pend <= 1'b0;
                            r_swap_done <= 1'b1;
                        end
                        if (w_cfg_apply) begin
                            r_drv_rows   <= r_pend_rows;
                            r_drv_cols   <= r_pend_cols;
                            r_drv_bits   <= r_pend_bits;
                            r_drv_blank  <= r_pend_blank;
                            r_drv_bright <= r_pend_bright;
                            r_cfg_pend   <= 1'b0;
                            r_cfg_done   <= 1'b1;
                        end
                        if (w_cfg_apply || w_wd_hit) begin
                            r_state   <= S_DRV_RST;
                            r_rst_cnt <= '0;
                            r_drv_rst <= 1'b1;
                            r_drv_en  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state   <= S_OFF;
                        r_drv_rst <= 1'b1;
                        r_drv_en  <= 1'b0;
                    end
                endcase
                // New requests win over same-edge application so none is lost
                if (sw_swap_req) begin
                    r_swap_pend <= 1'b1;
                end
                if (sw_cfg_wr && w_cfg_ok) begin
                    r_pend_rows   <= sw_n_rows;
                    r_pend_cols   <= sw_n_cols;
                    r_pend_bits   <= sw_bitdepth;
                    r_pend_blank  <= sw_lsb_blank;
                    r_pend_bright <= sw_brightness;
                    r_cfg_pend    <= 1'b1;
                end
            end
        end
    end

    assign drv_en         = r_drv_en;
    assign drv_rst        = r_drv_rst;
    assign drv_buffer     = r_drv_buf;
    assign wr_buffer      = ~r_drv_buf;
    assign drv_n_rows     = r_drv_rows;
    assign drv_n_cols     = r_drv_cols;
    assign drv_bitdepth   = r_drv_bits;
    assign drv_lsb_blank  = r_drv_blank;
    assign drv_brightness = r_drv_bright;
    assign swap_done      = r_swap_done;
    assign cfg_done       = r_cfg_done;
    assign cfg_err        = r_cfg_err;
    assign busy           = r_swap_pend | r_cfg_pend;

endmodule

// File: tb/tb_led_frame_sched.sv
// tb_led_frame_sched: directed scenarios plus random traffic against a
// cycle-level behavioural model of the frame scheduler.
module tb_led_frame_sched;
    localparam int W    = 32;
    localparam int RSTC = 4;
    localparam int WDOG = 100;
`ifdef FRAME_WATCHDOG_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         ctrl_rst_n;
    logic         sw_en;
    logic [W-1:0] sw_n_rows, sw_n_cols, sw_bitdepth, sw_lsb_blank, sw_brightness;
    logic         sw_cfg_wr, sw_swap_req, disp_sync;
    logic         drv_en, drv_rst, drv_buffer, wr_buffer;
    logic [W-1:0] drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness;
    logic         swap_done, cfg_done, cfg_err, busy, wdog_err;

    int errors = 0;
    int checks = 0;

    // model: mode 0=off 1=driver reset 2=run
    int          m_mode, m_left, m_quiet;
    bit          m_buf, m_sp, m_cp, m_prev, m_sd, m_cd, m_ce, m_wd;
    int unsigned m_drv[5];
    int unsigned m_pend[5];

    led_frame_sched #(
        .CTRL_REG_WIDTH(W),
        .RST_CYCLES(RSTC),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .ctrl_rst_n(ctrl_rst_n), .sw_en(sw_en),
        .sw_n_rows(sw_n_rows), .sw_n_cols(sw_n_cols),
        .sw_bitdepth(sw_bitdepth), .sw_lsb_blank(sw_lsb_blank),
        .sw_brightness(sw_brightness), .sw_cfg_wr(sw_cfg_wr),
        .sw_swap_req(sw_swap_req), .disp_sync(disp_sync),
        .drv_en(drv_en), .drv_rst(drv_rst),
        .drv_n_rows(drv_n_rows), .drv_n_cols(drv_n_cols),
        .drv_bitdepth(drv_bitdepth), .drv_lsb_blank(drv_lsb_blank),
        .drv_brightness(drv_brightness), .drv_buffer(drv_buffer),
        .wr_buffer(wr_buffer), .swap_done(swap_done), .cfg_done(cfg_done),
        .cfg_err(cfg_err), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic bit cfg_legal(int unsigned r, int unsigned c, int unsigned b,
                                     int unsigned l, int unsigned br);
        return (r >= 2) && (r <= 64) && (r % 2 == 0) && (c >= 1) && (c <= 256)
            && (b >= 1) && (b <= 8) && (l >= 1) && (l <= 200) && (br < l);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_quiet = 0;
        m_buf = 0; m_sp = 0; m_cp = 0; m_prev = 0;
        m_sd = 0; m_cd = 0; m_ce = 0; m_wd = 0;
        m_drv[0] = 64; m_drv[1] = 256; m_drv[2] = 8; m_drv[3] = 200; m_drv[4] = 0;
    endtask

    task automatic model_step();
        bit ev;
        bit ok;
        ev = disp_sync && !m_prev;
        ok = cfg_legal(sw_n_rows, sw_n_cols, sw_bitdepth, sw_lsb_blank, sw_brightness);
        m_sd = 0; m_cd = 0; m_wd = 0;
        m_ce = sw_cfg_wr && !ok;
        if (!sw_en) begin
            m_mode = 0; m_sp = 0; m_cp = 0;
        end else begin
            if (m_mode == 0) begin
                m_mode = 1; m_left = RSTC;
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) m_mode = 2;
            end else if (ev) begin
                m_quiet = 0;
                if (m_sp) begin m_buf = !m_buf; m_sp = 0; m_sd = 1; end
                if (m_cp) begin
                    m_drv = m_pend; m_cp = 0; m_cd = 1;
                    m_mode = 1; m_left = RSTC;
                end
            end else if (WD_ON) begin
                m_quiet++;
                if (m_quiet == WDOG) begin
                    m_wd = 1; m_quiet = 0; m_mode = 1; m_left = RSTC;
                end
            end
            if (sw_swap_req) m_sp = 1;
            if (sw_cfg_wr && ok) begin
                m_pend[0] = sw_n_rows; m_pend[1] = sw_n_cols; m_pend[2] = sw_bitdepth;
                m_pend[3] = sw_lsb_blank; m_pend[4] = sw_brightness;
                m_cp = 1;
            end
        end
        if (m_mode != 2) m_quiet = 0;
        m_prev = disp_sync;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(int unsigned r, int unsigned c, int unsigned b,
                           int unsigned l, int unsigned br);
        sw_n_rows = r; sw_n_cols = c; sw_bitdepth = b;
        sw_lsb_blank = l; sw_brightness = br;
    endtask

    task automatic wait_run(output bit ok);
        int n = 0;
        while (drv_en !== 1'b1 && n < 50) begin cyc(); n++; end
        ok = (drv_en === 1'b1);
    endtask

    task automatic test_reset();
        ctrl_rst_n = 0; sw_en = 0; sw_cfg_wr = 0; sw_swap_req = 0; disp_sync = 0;
        set_cfg(0, 0, 0, 0, 0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({drv_en, drv_rst} !== 2'b01) begin
            errors++; $display("FAIL reset_en_rst: got %b%b required 01", drv_en, drv_rst);
        end
        checks++;
        if ({drv_buffer, wr_buffer} !== 2'b01) begin
            errors++; $display("FAIL reset_buf: got %b%b required 01", drv_buffer, wr_buffer);
        end
        checks++;
        if ({drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness} !==
            {32'd64, 32'd256, 32'd8, 32'd200, 32'd0}) begin
            errors++;
            $display("FAIL reset_cfg: got %0d %0d %0d %0d %0d required 64 256 8 200 0",
                     drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness);
        end
        checks++;
        if ({swap_done, cfg_done, cfg_err, wdog_err, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b%b%b%b%b required 00000",
                     swap_done, cfg_done, cfg_err, wdog_err, busy);
        end
        #2 ctrl_rst_n = 1;
        cyc(); cyc();
        checks++;
        if ({drv_en, drv_rst, swap_done, cfg_done, cfg_err, wdog_err, busy} !== 7'b0100000) begin
            errors++;
            $display("FAIL release_quiet: got %b%b%b%b%b%b%b required 0100000",
                     drv_en, drv_rst, swap_done, cfg_done, cfg_err, wdog_err, busy);
        end
    endtask

    task automatic test_startup();
        int n = 0;
        bit rst_hi = 1;
        sw_en = 1;
        cyc();
        while (drv_en !== 1'b1 && n < 20) begin
            if (drv_rst !== 1'b1) rst_hi = 0;
            n++;
            cyc();
        end
        checks++;
        if (n != RSTC || !rst_hi) begin
            errors++; $display("FAIL startup_len: got %0d rst_hi=%b required %0d 1", n, rst_hi, RSTC);
        end
        checks++;
        if ({drv_rst, drv_buffer, drv_n_rows} !== {1'b0, 1'b0, 32'd64}) begin
            errors++;
            $display("FAIL startup_run: got rst=%b buf=%b rows=%0d required 0 0 64",
                     drv_rst, drv_buffer, drv_n_rows);
        end
    endtask

    task automatic test_swap();
        int sd = 0;
        sw_swap_req = 1; cyc(); sw_swap_req = 0; cyc();
        sw_swap_req = 1; cyc(); sw_swap_req = 0;
        checks++;
        if ({busy, drv_buffer} !== 2'b10) begin
            errors++; $display("FAIL swap_pending: got busy=%b buf=%b required 1 0", busy, drv_buffer);
        end
        disp_sync = 1; cyc(); disp_sync = 0;
        checks++;
        if ({drv_buffer, wr_buffer, swap_done, busy} !== 4'b1010) begin
            errors++;
            $display("FAIL swap_apply: got %b%b%b%b required 1010",
                     drv_buffer, wr_buffer, swap_done, busy);
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (swap_done === 1'b1 || drv_buffer !== 1'b1) sd++;
        end
        checks++;
        if (sd != 0) begin
            errors++; $display("FAIL swap_once: got %0d extra events required 0", sd);
        end
    endtask

    task automatic test_cfg();
        int n = 1;
        set_cfg(32, 128, 6, 100, 20);
        sw_cfg_wr = 1; cyc(); sw_cfg_wr = 0; cyc();
        checks++;
        if ({busy, cfg_done, drv_n_rows} !== {1'b1, 1'b0, 32'd64}) begin
            errors++;
            $display("FAIL cfg_pending: got busy=%b done=%b rows=%0d required 1 0 64",
                     busy, cfg_done, drv_n_rows);
        end
        disp_sync = 1; cyc(); disp_sync = 0;
        checks++;
        if ({drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness} !==
            {32'd32, 32'd128, 32'd6, 32'd100, 32'd20}) begin
            errors++;
            $display("FAIL cfg_apply: got %0d %0d %0d %0d %0d required 32 128 6 100 20",
                     drv_n_rows, drv_n_cols, drv_bitdepth, drv_lsb_blank, drv_brightness);
        end
        checks++;
        if ({cfg_done, busy, drv_rst, drv_en} !== 4'b1010) begin
            errors++;
            $display("FAIL cfg_done: got %b%b%b%b required 1010", cfg_done, busy, drv_rst, drv_en);
        end
        while (n < 20) begin
            cyc();
            if (drv_rst !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != RSTC || drv_en !== 1'b1) begin
            errors++; $display("FAIL cfg_rst_len: got %0d en=%b required %0d 1", n, drv_en, RSTC);
        end
    endtask

    task automatic test_cfg_err();
        set_cfg(33, 128, 6, 100, 20);
        sw_cfg_wr = 1; cyc(); sw_cfg_wr = 0;
        checks++;
        if ({cfg_err, busy, drv_n_rows} !== {1'b1, 1'b0, 32'd32}) begin
            errors++;
            $display("FAIL cfg_err_odd: got err=%b busy=%b rows=%0d required 1 0 32",
                     cfg_err, busy, drv_n_rows);
        end
        cyc();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++; $display("FAIL cfg_err_pulse: got %b required 0", cfg_err);
        end
        set_cfg(32, 128, 6, 100, 100);
        sw_cfg_wr = 1; cyc(); sw_cfg_wr = 0;
        checks++;
        if ({cfg_err, busy, drv_brightness} !== {1'b1, 1'b0, 32'd20}) begin
            errors++;
            $display("FAIL cfg_err_bright: got err=%b busy=%b br=%0d required 1 0 20",
                     cfg_err, busy, drv_brightness);
        end
        set_cfg(64, 256, 8, 200, 199);
        sw_cfg_wr = 1; cyc(); sw_cfg_wr = 0;
        checks++;
        if ({cfg_err, busy} !== 2'b01) begin
            errors++; $display("FAIL cfg_max_ok: got err=%b busy=%b required 0 1", cfg_err, busy);
        end
    endtask

    task automatic test_both_off();
        bit ok;
        set_cfg(2, 1, 1, 1, 0);
        sw_cfg_wr = 1; sw_swap_req = 1; cyc(); sw_cfg_wr = 0; sw_swap_req = 0;
        disp_sync = 1; cyc(); disp_sync = 0;
        checks++;
        if ({drv_buffer, swap_done, cfg_done, drv_rst, busy, drv_n_rows} !==
            {5'b01110, 32'd2}) begin
            errors++;
            $display("FAIL both_apply: got buf=%b sd=%b cd=%b rst=%b busy=%b rows=%0d required 0 1 1 1 0 2",
                     drv_buffer, swap_done, cfg_done, drv_rst, busy, drv_n_rows);
        end
        set_cfg(10, 10, 3, 50, 5);
        sw_cfg_wr = 1; sw_swap_req = 1; cyc(); sw_cfg_wr = 0; sw_swap_req = 0;
        disp_sync = 1; cyc(); disp_sync = 0;
        checks++;
        if ({busy, drv_rst, drv_buffer, swap_done, drv_n_rows} !== {4'b1100, 32'd2}) begin
            errors++;
            $display("FAIL rst_no_sync: got busy=%b rst=%b buf=%b sd=%b rows=%0d required 1 1 0 0 2",
                     busy, drv_rst, drv_buffer, swap_done, drv_n_rows);
        end
        sw_en = 0; cyc(); cyc();
        checks++;
        if ({drv_en, drv_rst, busy, drv_buffer} !== 4'b0100) begin
            errors++;
            $display("FAIL off_clear: got %b%b%b%b required 0100", drv_en, drv_rst, busy, drv_buffer);
        end
        sw_en = 1;
        wait_run(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL rerun: drv_en=%b required 1", drv_en);
        end
    endtask

`ifdef FRAME_WATCHDOG_EN
    task automatic test_watchdog();
        int n = 0;
        bit ok;
        sw_swap_req = 1; cyc(); sw_swap_req = 0; n = 1;
        while (wdog_err !== 1'b1 && n < 300) begin cyc(); n++; end
        checks++;
        if (n != WDOG) begin
            errors++; $display("FAIL wdog_len: got %0d cycles required %0d", n, WDOG);
        end
        checks++;
        if ({drv_rst, drv_en, busy} !== 3'b101) begin
            errors++; $display("FAIL wdog_rst: got %b%b%b required 101", drv_rst, drv_en, busy);
        end
        cyc();
        checks++;
        if (wdog_err !== 1'b0) begin
            errors++; $display("FAIL wdog_pulse: got %b required 0", wdog_err);
        end
        wait_run(ok);
        disp_sync = 1; cyc(); disp_sync = 0;
        checks++;
        if (!ok || swap_done !== 1'b1) begin
            errors++; $display("FAIL wdog_resume: got run=%b sd=%b required 1 1", ok, swap_done);
        end
    endtask
`else
    task automatic test_no_wdog();
        int bad = 0;
        for (int i = 0; i < 150; i++) begin
            cyc();
            if (wdog_err !== 1'b0 || drv_en !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL no_wdog: got %0d bad cycles required 0", bad);
        end
    endtask
`endif

    task automatic test_async_reset();
        bit ok;
        set_cfg(20, 20, 2, 30, 3);
        sw_cfg_wr = 1; sw_swap_req = 1; cyc(); sw_cfg_wr = 0; sw_swap_req = 0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL arst_pre: busy=%b required 1", busy);
        end
        #2 ctrl_rst_n = 0;
        #1;
        model_reset();
        checks++;
        if ({busy, drv_rst, drv_en, drv_buffer, drv_n_rows} !== {4'b0100, 32'd64}) begin
            errors++;
            $display("FAIL arst_now: got busy=%b rst=%b en=%b buf=%b rows=%0d required 0 1 0 0 64",
                     busy, drv_rst, drv_en, drv_buffer, drv_n_rows);
        end
        #2 ctrl_rst_n = 1;
        cyc();
        checks++;
        if ({busy, swap_done, cfg_done, cfg_err, wdog_err} !== 5'b0) begin
            errors++;
            $display("FAIL arst_release: got %b%b%b%b%b required 00000",
                     busy, swap_done, cfg_done, cfg_err, wdog_err);
        end
        wait_run(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL arst_run: drv_en=%b required 1", drv_en);
        end
    endtask

    task automatic test_random();
        logic [168:0] got, exp;
        int unsigned l;
        for (int i = 0; i < 3000; i++) begin
            sw_en = ($urandom_range(0, 99) != 0);
            disp_sync = (i >= 1000 && i < 1400) ? 1'b0 : ($urandom_range(0, 15) == 0);
            sw_swap_req = ($urandom_range(0, 7) == 0);
            sw_cfg_wr = ($urandom_range(0, 9) == 0);
            l = $urandom_range(0, 202);
            sw_n_rows = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 66));
            sw_n_cols = 32'($urandom_range(0, 258));
            sw_bitdepth = 32'($urandom_range(0, 9));
            sw_lsb_blank = l;
            sw_brightness = 32'($urandom_range(0, l + 2));
            cyc();
            got = {drv_en, drv_rst, drv_buffer, wr_buffer, swap_done, cfg_done,
                   cfg_err, busy, wdog_err, drv_n_rows, drv_n_cols, drv_bitdepth,
                   drv_lsb_blank, drv_brightness};
            exp = {m_mode == 2, m_mode != 2, m_buf, !m_buf, m_sd, m_cd, m_ce,
                   m_sp | m_cp, m_wd, 32'(m_drv[0]), 32'(m_drv[1]), 32'(m_drv[2]),
                   32'(m_drv[3]), 32'(m_drv[4])};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h required %h", i, got, exp);
            end
        end
        sw_cfg_wr = 0; sw_swap_req = 0; disp_sync = 0; sw_en = 1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_swap();
        test_cfg();
        test_cfg_err();
        test_both_off();
`ifdef FRAME_WATCHDOG_EN
        test_watchdog();
`else
        test_no_wdog();
`endif
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
